// File: rtl/seg_scan_driver_if.sv
// Bus between the symbol register and the 7-segment scan driver.
// The master drives the enable and the four symbol codes; the slave returns the digit strobes, segments and frame pulse.
interface seg_scan_if;
    logic       en;
    logic [2:0] d0;
    logic [2:0] d1;
    logic [2:0] d2;
    logic [2:0] d3;
    logic [3:0] ssd_ctl;
    logic [7:0] segs;
    logic       frame_done;

    modport master (
        output en, d0, d1, d2, d3,
        input  ssd_ctl, segs, frame_done
    );

    modport slave (
        input  en, d0, d1, d2, d3,
        output ssd_ctl, segs, frame_done
    );
endinterface

// File: rtl/seg_scan_driver.sv
// Tear-free 4-digit common-anode 7-segment scanner with a per-frame window snapshot.
// Optional macro SEG_SCAN_BLANK_GAP_EN inserts a one-cycle all-off gap at each digit change (anti-ghosting).
module seg_scan_driver #(
    parameter int SCAN_DIV = 50000,
    parameter int CNT_W    = 16
) (
    input  logic      clk,
    input  logic      rst,
    seg_scan_if.slave bus
);
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [1:0]       sel_r;
    logic [11:0]      snap_r;
    logic [3:0]       ssd_ctl_r;
    logic [7:0]       segs_r;
    logic             frame_done_r;
`ifdef SEG_SCAN_BLANK_GAP_EN
    logic             gap_r;
`endif

    logic             tick_s;
    state_t           state_next_s;
    logic [1:0]       sel_next_s;
    logic [11:0]      snap_next_s;
    logic             fd_next_s;

    // Active-low {a,b,c,d,e,f,g,dp}; dp stays dark.
    function automatic logic [7:0] glyph(input logic [2:0] code);
        logic [7:0] g;
        case (code)
            3'd0:    g = 8'b0000_0011;
            3'd1:    g = 8'b1001_1111;
            3'd2:    g = 8'b0010_0101;
            3'd3:    g = 8'b0000_1101;
            3'd4:    g = 8'b1001_1001;
            3'd5:    g = 8'b0100_1001;
            3'd6:    g = 8'b0100_0001;
            3'd7:    g = 8'b0001_1111;
            default: g = 8'hFF;
        endcase
        return g;
    endfunction

    function automatic logic [2:0] pick(input logic [11:0] win, input logic [1:0] idx);
        logic [2:0] c;
        case (idx)
            2'd0:    c = win[2:0];
            2'd1:    c = win[5:3];
            2'd2:    c = win[8:6];
            2'd3:    c = win[11:9];
            default: c = 3'd0;
        endcase
        return c;
    endfunction

    function automatic logic [3:0] digit_ctl(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

    // Next scan position, snapshot and frame pulse for the upcoming tick edge.
    always_comb begin
        tick_s       = bus.en && (cnt_r == CNT_LAST);
        state_next_s = state_r;
        sel_next_s   = sel_r;
        snap_next_s  = snap_r;
        fd_next_s    = 1'b0;
        if (tick_s) begin
            case (state_r)
                IDLE: begin
                    snap_next_s  = {bus.d3, bus.d2, bus.d1, bus.d0};
                    sel_next_s   = 2'd0;
                    state_next_s = SCAN;
                end
                SCAN: begin
                    if (sel_r == 2'd3) begin
                        sel_next_s  = 2'd0;
                        snap_next_s = {bus.d3, bus.d2, bus.d1, bus.d0};
                        fd_next_s   = 1'b1;
                    end else begin
                        sel_next_s  = sel_r + 2'd1;
                    end
                end
                default: begin
                    state_next_s = IDLE;
                    sel_next_s   = 2'd0;
                end
            endcase
        end else begin
            fd_next_s = 1'b0;
        end
    end

    // Prescaler, scan FSM and registered display outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r        <= '0;
            sel_r        <= 2'd0;
            snap_r       <= 12'd0;
            state_r      <= IDLE;
            ssd_ctl_r    <= 4'b1111;
            segs_r       <= 8'hFF;
            frame_done_r <= 1'b0;
`ifdef SEG_SCAN_BLANK_GAP_EN
            gap_r        <= 1'b0;
`endif
        end else if (bus.en) begin
            cnt_r        <= tick_s ? '0 : (cnt_r + CNT_ONE);
            sel_r        <= sel_next_s;
            snap_r       <= snap_next_s;
            state_r      <= state_next_s;
            frame_done_r <= fd_next_s;
`ifdef SEG_SCAN_BLANK_GAP_EN
            // Blank for one cycle, then light the digit already latched in sel/snapshot.
            if (tick_s) begin
                ssd_ctl_r <= 4'b1111;
                segs_r    <= 8'hFF;
                gap_r     <= 1'b1;
            end else if (gap_r) begin
                ssd_ctl_r <= digit_ctl(sel_r);
                segs_r    <= glyph(pick(snap_r, sel_r));
                gap_r     <= 1'b0;
            end else begin
                gap_r     <= 1'b0;
            end
`else
            if (tick_s) begin
                ssd_ctl_r <= digit_ctl(sel_next_s);
                segs_r    <= glyph(pick(snap_next_s, sel_next_s));
            end
`endif
        end else begin
            // Frozen scan; the frame pulse still self-clears so it never stretches.
            frame_done_r <= 1'b0;
        end
    end

    assign bus.ssd_ctl    = ssd_ctl_r;
    assign bus.segs       = segs_r;
    assign bus.frame_done = frame_done_r;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed, table-driven bench for seg_scan_driver with SCAN_DIV=4; expectations follow SEG_SCAN_BLANK_GAP_EN.
module tb_seg_scan_driver;
    localparam int SCAN_DIV = 4;
    localparam int CNT_W    = 3;
`ifdef SEG_SCAN_BLANK_GAP_EN
    localparam bit GAP = 1'b1;
`else
    localparam bit GAP = 1'b0;
`endif

    typedef struct {
        logic        rst;
        logic        en;
        logic [11:0] d;
        int          n;
        logic [3:0]  ctl;
        logic [7:0]  segs;
        logic        fd;
    } vec_t;

    localparam int NV = 32;
    vec_t tbl [NV];

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    seg_scan_if bus ();

    seg_scan_driver #(
        .SCAN_DIV (SCAN_DIV),
        .CNT_W    (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic e, input logic [11:0] d, input int n,
                                input logic [3:0] c, input logic [7:0] s, input logic f);
        vec_t v;
        v.rst = r; v.en = e; v.d = d; v.n = n; v.ctl = c; v.segs = s; v.fd = f;
        return v;
    endfunction

    // Tick-edge rows: the gap build shows all-off on that cycle.
    function automatic vec_t tk(input logic [11:0] d, input logic [3:0] c, input logic [7:0] s, input logic f);
        return mk(1'b0, 1'b1, d, 1, GAP ? 4'b1111 : c, GAP ? 8'hFF : s, f);
    endfunction

    task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic clocks(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    logic [11:0] w3210;
    logic [11:0] w3217;
    logic [11:0] w6540;
    int fd_cnt, onehot_cnt, blank_cnt, fd_double;
    logic fd_prev;

    initial begin
        w3210 = {3'd3, 3'd2, 3'd1, 3'd0};
        w3217 = {3'd3, 3'd2, 3'd1, 3'd7};
        w6540 = {3'd6, 3'd5, 3'd4, 3'd0};

        // reset, first frame
        tbl[0]  = mk(1'b1, 1'b1, w3210, 1, 4'b1111, 8'hFF, 1'b0);
        tbl[1]  = mk(1'b0, 1'b1, w3210, 3, 4'b1111, 8'hFF, 1'b0);
        tbl[2]  = tk(w3210, 4'b1110, 8'h03, 1'b0);
        tbl[3]  = mk(1'b0, 1'b1, w3210, 1, 4'b1110, 8'h03, 1'b0);
        tbl[4]  = mk(1'b0, 1'b1, w3210, 4, 4'b1101, 8'h9F, 1'b0);
        tbl[5]  = mk(1'b0, 1'b1, w3210, 4, 4'b1011, 8'h25, 1'b0);
        tbl[6]  = mk(1'b0, 1'b1, w3210, 4, 4'b0111, 8'h0D, 1'b0);
        tbl[7]  = mk(1'b0, 1'b1, w3210, 3, GAP ? 4'b1111 : 4'b1110, GAP ? 8'hFF : 8'h03, 1'b1);
        tbl[8]  = mk(1'b0, 1'b1, w3210, 1, 4'b1110, 8'h03, 1'b0);
        tbl[9]  = mk(1'b0, 1'b1, w3210, 4, 4'b1101, 8'h9F, 1'b0);
        // d0 changes while sel=1; new value only after the frame boundary
        tbl[10] = mk(1'b0, 1'b1, w3217, 4, 4'b1011, 8'h25, 1'b0);
        tbl[11] = mk(1'b0, 1'b1, w3217, 4, 4'b0111, 8'h0D, 1'b0);
        tbl[12] = mk(1'b0, 1'b1, w3217, 3, GAP ? 4'b1111 : 4'b1110, GAP ? 8'hFF : 8'h1F, 1'b1);
        tbl[13] = mk(1'b0, 1'b1, w3217, 1, 4'b1110, 8'h1F, 1'b0);
        tbl[14] = mk(1'b0, 1'b1, w3217, 4, 4'b1101, 8'h9F, 1'b0);
        tbl[15] = mk(1'b0, 1'b1, w3217, 4, 4'b1011, 8'h25, 1'b0);
        // enable freeze at sel=2, cnt=1
        tbl[16] = mk(1'b0, 1'b0, w3217, 10, 4'b1011, 8'h25, 1'b0);
        tbl[17] = mk(1'b0, 1'b1, w3217, 2, 4'b1011, 8'h25, 1'b0);
        tbl[18] = tk(w3217, 4'b0111, 8'h0D, 1'b0);
        tbl[19] = mk(1'b0, 1'b1, w3217, 1, 4'b0111, 8'h0D, 1'b0);
        // reset mid-scan at sel=3
        tbl[20] = mk(1'b1, 1'b1, w3217, 1, 4'b1111, 8'hFF, 1'b0);
        tbl[21] = mk(1'b0, 1'b1, w3217, 3, 4'b1111, 8'hFF, 1'b0);
        tbl[22] = tk(w3217, 4'b1110, 8'h1F, 1'b0);
        tbl[23] = mk(1'b0, 1'b1, w3217, 1, 4'b1110, 8'h1F, 1'b0);
        // new window for glyphs 4..6, visible next frame
        tbl[24] = mk(1'b0, 1'b1, w6540, 4, 4'b1101, 8'h9F, 1'b0);
        tbl[25] = mk(1'b0, 1'b1, w6540, 4, 4'b1011, 8'h25, 1'b0);
        tbl[26] = mk(1'b0, 1'b1, w6540, 4, 4'b0111, 8'h0D, 1'b0);
        tbl[27] = mk(1'b0, 1'b1, w6540, 3, GAP ? 4'b1111 : 4'b1110, GAP ? 8'hFF : 8'h03, 1'b1);
        tbl[28] = mk(1'b0, 1'b1, w6540, 1, 4'b1110, 8'h03, 1'b0);
        tbl[29] = mk(1'b0, 1'b1, w6540, 4, 4'b1101, 8'h99, 1'b0);
        tbl[30] = mk(1'b0, 1'b1, w6540, 4, 4'b1011, 8'h49, 1'b0);
        tbl[31] = mk(1'b0, 1'b1, w6540, 4, 4'b0111, 8'h41, 1'b0);

        rst    = 1'b1;
        bus.en = 1'b0;
        {bus.d3, bus.d2, bus.d1, bus.d0} = 12'd0;
        #2;

        for (int i = 0; i < NV; i++) begin
            rst    = tbl[i].rst;
            bus.en = tbl[i].en;
            {bus.d3, bus.d2, bus.d1, bus.d0} = tbl[i].d;
            clocks(tbl[i].n);
            chk("ssd_ctl", i, {4'b0000, bus.ssd_ctl}, {4'b0000, tbl[i].ctl});
            chk("segs", i, bus.segs, tbl[i].segs);
            chk("frame_done", i, {7'd0, bus.frame_done}, {7'd0, tbl[i].fd});
        end

        // 64 free-running cycles from sel=3, cnt=1: 16 ticks, 4 frame ends
        fd_cnt = 0; onehot_cnt = 0; blank_cnt = 0; fd_double = 0; fd_prev = 1'b0;
        for (int c = 0; c < 64; c++) begin
            clocks(1);
            if (bus.frame_done) fd_cnt++;
            if (bus.frame_done && fd_prev) fd_double++;
            fd_prev = bus.frame_done;
            if ($countones(~bus.ssd_ctl) == 1) onehot_cnt++;
            if (bus.ssd_ctl == 4'b1111) blank_cnt++;
        end
        chk("frame_count", 100, 8'(fd_cnt), 8'd4);
        chk("frame_stretch", 101, 8'(fd_double), 8'd0);
        chk("onehot_cycles", 102, 8'(onehot_cnt), GAP ? 8'd48 : 8'd64);
        chk("blank_cycles", 103, 8'(blank_cnt), GAP ? 8'd16 : 8'd0);

        // reset wins over en=0, then a clean restart from IDLE
        rst = 1'b1; bus.en = 1'b0;
        clocks(1);
        chk("rst_over_en_ctl", 110, {4'b0000, bus.ssd_ctl}, 8'h0F);
        chk("rst_over_en_segs", 111, bus.segs, 8'hFF);
        rst = 1'b0; bus.en = 1'b1;
        {bus.d3, bus.d2, bus.d1, bus.d0} = w3210;
        clocks(3);
        chk("restart_idle_ctl", 112, {4'b0000, bus.ssd_ctl}, 8'h0F);
        clocks(2);
        chk("restart_ctl", 113, {4'b0000, bus.ssd_ctl}, 8'h0E);
        chk("restart_segs", 114, bus.segs, 8'h03);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
